// File: rtl/run_dump_pkg.sv
// rtl/run_dump_pkg.sv - shared types, defaults and helpers for the run/dump controller
//
// Purpose: state encodings for the run controller and the dump engine, default
// parameter values, and the line-end helper used when a dump beat is captured.
// Ports: none (package).

package run_dump_pkg;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_LEN_W          = 16;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_RESET_CYCLES   = 3;
  localparam int DEF_MAX_CYCLES     = 100000;
  localparam int DEF_WORDS_PER_LINE = 16;

  // Run controller: the DUMP state covers RD_REQ/RD_CAP/OUT, which the dump
  // engine sequences on its own.
  typedef enum logic [2:0] {
    CTRL_IDLE,
    CTRL_RST_HOLD,
    CTRL_RUN,
    CTRL_DUMP,
    CTRL_DONE
  } ctrl_state_e;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_RD_REQ,
    DUMP_RD_CAP,
    DUMP_OUT
  } dump_state_e;

  // A position counter that wraps every wpl beats marks a line end when it
  // sits on its last slot; this avoids a modulo by an arbitrary constant.
  function automatic logic line_end(input logic [31:0] pos, input int unsigned wpl);
    return pos == (wpl - 32'd1);
  endfunction

endpackage

// File: rtl/dump_engine.sv
// rtl/dump_engine.sv - memory window walker streaming words over valid/ready
//
// Purpose: on start, reads len words from base upward (address wraps) through a
// one-cycle-latency debug read port and presents each word as one beat.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle pulse, begins a dump (ignored unless idle)
//   base, len          window start address and word count (held by caller)
//   mem_rd, mem_addr   debug read strobe and address
//   mem_rdata          read data, valid the cycle after mem_rd
//   out_valid/ready    beat handshake
//   out_data/eol/last  beat word, end-of-line flag, end-of-dump flag
//   done               one-cycle pulse on the handshake of the last beat

module dump_engine
  import run_dump_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  output logic              out_last,
  output logic              done
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  dump_state_e       st_q, st_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  line_q, line_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              eol_q, eol_d;
  logic              last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= DUMP_IDLE;
      idx_q  <= '0;
      line_q <= '0;
      data_q <= '0;
      eol_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      line_q <= line_d;
      data_q <= data_d;
      eol_q  <= eol_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    line_d = line_q;
    data_d = data_q;
    eol_d  = eol_q;
    last_d = last_q;
    done   = 1'b0;
    unique case (st_q)
      DUMP_IDLE: begin
        if (start) begin
          idx_d  = '0;
          line_d = '0;
          st_d   = DUMP_RD_REQ;
        end
      end
      DUMP_RD_REQ: st_d = DUMP_RD_CAP;
      DUMP_RD_CAP: begin
        // Beat word and flags are frozen here so they cannot change while the
        // sink stalls.
        data_d = mem_rdata;
        eol_d  = line_end(32'(line_q), WORDS_PER_LINE);
        last_d = ((idx_q + LEN_ONE) == len);
        st_d   = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (out_ready) begin
          idx_d  = idx_q + LEN_ONE;
          line_d = eol_q ? '0 : (line_q + LEN_ONE);
          if (last_q) begin
            st_d = DUMP_IDLE;
            done = 1'b1;
          end else begin
            st_d = DUMP_RD_REQ;
          end
        end
      end
      default: st_d = DUMP_IDLE;
    endcase
  end

  assign mem_rd    = (st_q == DUMP_RD_REQ);
  assign mem_addr  = mem_rd ? (base + ADDR_W'(idx_q)) : '0;
  assign out_valid = (st_q == DUMP_OUT);
  assign out_data  = data_q;
  assign out_eol   = eol_q;
  assign out_last  = last_q;

endmodule

// File: rtl/run_dump_controller.sv
// rtl/run_dump_controller.sv - core run control with PC/timeout completion and memory dump
//
// Purpose: holds the core in reset for RESET_CYCLES after Start, runs it until
// the fetch PC hits End_PC or MAX_CYCLES elapse, then dumps Dump_Len words from
// Dump_Base through dump_engine while the core is held in reset again.
// Ports:
//   Clk, Reset                   clock, asynchronous active-low reset
//   Start                        one-cycle pulse, honoured in idle/done only
//   End_PC, Dump_Base, Dump_Len  run parameters, latched at Start
//   PC                           core fetch PC
//   Core_Reset                   active-high reset to the core
//   Mem_Rd, Mem_Addr, Mem_Rdata  debug read port (1-cycle latency)
//   Out_Valid/Ready/Data/Eol/Last dump stream
//   Busy, Done, Timeout          status
//   Cycle_Count                  RUN cycles elapsed, saturating

module run_dump_controller
  import run_dump_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int MAX_CYCLES     = DEF_MAX_CYCLES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] End_PC,
  input  logic [ADDR_W-1:0] Dump_Base,
  input  logic [LEN_W-1:0]  Dump_Len,
  input  logic [ADDR_W-1:0] PC,
  output logic              Core_Reset,
  output logic              Mem_Rd,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Eol,
  output logic              Out_Last,
  output logic              Busy,
  output logic              Done,
  output logic              Timeout,
  output logic [CNT_W-1:0]  Cycle_Count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] end_pc_q, end_pc_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              pc_hit;
  logic              limit_hit;
  logic              dump_start;
  logic              dump_done;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= CTRL_IDLE;
      end_pc_q  <= '0;
      base_q    <= '0;
      len_q     <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      end_pc_q  <= end_pc_d;
      base_q    <= base_d;
      len_q     <= len_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    end_pc_d   = end_pc_q;
    base_d     = base_q;
    len_d      = len_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    dump_start = 1'b0;
    cnt_inc    = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_ONE);
    pc_hit     = 1'b0;
    limit_hit  = 1'b0;
    unique case (state_q)
      CTRL_IDLE, CTRL_DONE: begin
        if (Start) begin
          end_pc_d  = End_PC;
          base_d    = Dump_Base;
          len_d     = Dump_Len;
          hold_d    = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
          state_d   = CTRL_RST_HOLD;
        end
      end
      CTRL_RST_HOLD: begin
        if (hold_q == 32'(RESET_CYCLES - 1)) state_d = CTRL_RUN;
        else                                 hold_d  = hold_q + 32'd1;
      end
      CTRL_RUN: begin
        // The count already includes the current cycle when the exit is
        // decided, so a hit on the Nth RUN cycle leaves Cycle_Count at N.
        cnt_d     = cnt_inc;
        pc_hit    = (PC == end_pc_q);
        limit_hit = (cnt_inc >= CNT_W'(MAX_CYCLES));
        if (pc_hit || limit_hit) begin
          timeout_d = !pc_hit;
          if (len_q == '0) begin
            state_d = CTRL_DONE;
          end else begin
            state_d    = CTRL_DUMP;
            dump_start = 1'b1;
          end
        end
      end
      CTRL_DUMP: begin
        if (dump_done) state_d = CTRL_DONE;
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  dump_engine #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .LEN_W         (LEN_W),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_dump_engine (
    .clk      (Clk),
    .rst_n    (Reset),
    .start    (dump_start),
    .base     (base_q),
    .len      (len_q),
    .mem_rd   (Mem_Rd),
    .mem_addr (Mem_Addr),
    .mem_rdata(Mem_Rdata),
    .out_valid(Out_Valid),
    .out_ready(Out_Ready),
    .out_data (Out_Data),
    .out_eol  (Out_Eol),
    .out_last (Out_Last),
    .done     (dump_done)
  );

  assign Core_Reset  = (state_q != CTRL_RUN);
  assign Busy        = (state_q != CTRL_IDLE) && (state_q != CTRL_DONE);
  assign Done        = (state_q == CTRL_DONE);
  assign Timeout     = timeout_q;
  assign Cycle_Count = cnt_q;

endmodule

// File: doc/run_dump_controller.md
Name: run_dump_controller

Overview:
Synthesizable run-control and memory-dump engine for the pipelined datapath. It holds the core in reset for a programmable number of cycles and then lets it run. It detects program completion by fetch-PC match or by cycle timeout, then walks a window of data memory and streams the words out over a valid/ready interface. It sits beside Data_Path, driving the core's active-high reset and the data-memory debug read port, and replaces ad-hoc end-of-run memory printing.

Parameters:
ADDR_W, 32, width of PC and memory word address
DATA_W, 32, memory word width
LEN_W, 16, width of dump length
CNT_W, 32, width of cycle counter
RESET_CYCLES, 3, cycles Core_Reset stays high after Start (min 1)
MAX_CYCLES, 100000, RUN-state cycle limit before timeout (min 1)
WORDS_PER_LINE, 16, Out_Eol period in beats (min 1)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low
Start  in  1  one-cycle pulse, begins a run
End_PC  in  ADDR_W  completion PC, latched at Start
Dump_Base  in  ADDR_W  first word address to dump, latched at Start
Dump_Len  in  LEN_W  number of words to dump, latched at Start
PC  in  ADDR_W  core fetch PC (PCF)
Core_Reset  out  1  active-high reset to Data_Path
Mem_Rd  out  1  debug read strobe
Mem_Addr  out  ADDR_W  debug read address
Mem_Rdata  in  DATA_W  read data, valid exactly 1 cycle after Mem_Rd
Out_Valid  out  1  dump beat valid
Out_Ready  in  1  sink accepts beat
Out_Data  out  DATA_W  dump word
Out_Eol  out  1  beat is last of a line
Out_Last  out  1  beat is last of dump
Busy  out  1  high in any state other than IDLE/DONE
Done  out  1  run and dump complete
Timeout  out  1  run ended by MAX_CYCLES, not PC match
Cycle_Count  out  CNT_W  RUN cycles elapsed, saturating

Behaviour:
- States: IDLE, RST_HOLD, RUN, RD_REQ, RD_CAP, OUT, DONE.
- Reset (Reset=0, async): state=IDLE; Core_Reset=1; Mem_Rd=0; Mem_Addr=0; Out_Valid=0; Out_Data=0; Out_Eol=0; Out_Last=0; Busy=0; Done=0; Timeout=0; Cycle_Count=0. Reset mid-run or mid-dump aborts immediately; no partial beat survives.
- IDLE/DONE: Core_Reset=1. Start=1 -> latch End_PC/Dump_Base/Dump_Len, clear Done, Timeout, Cycle_Count, beat index; go to RST_HOLD. Start ignored in all other states.
- RST_HOLD: Core_Reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN: Core_Reset=0; Cycle_Count increments each cycle, saturating at all-ones. Exit when PC==latched End_PC (compare registered, Timeout=0) or when Cycle_Count reaches MAX_CYCLES (Timeout=1). Both true in the same cycle -> PC match wins, Timeout=0. On exit Core_Reset returns to 1 the next cycle and the core stays frozen during the dump.
- Dump_Len==0 -> RUN exits directly to DONE with no beats.
- RD_REQ: Mem_Rd=1 for one cycle; Mem_Addr = Dump_Base + index, modulo 2^ADDR_W (wraps). Next state RD_CAP.
- RD_CAP: register Mem_Rdata into Out_Data. Set Out_Eol=((index+1) mod WORDS_PER_LINE==0) and Out_Last=(index+1==Dump_Len). Next state OUT.
- OUT: Out_Valid=1. Out_Data, Out_Eol and Out_Last stay stable while Out_Ready=0. A handshake (Valid&Ready) increments index. Then DONE if that beat was Last, else RD_REQ. Out_Valid drops the cycle after the handshake.
- Throughput: 1 beat per 3 cycles when Out_Ready is held high.
- DONE: Done=1, Busy=0. Timeout and Cycle_Count hold until the next Start or Reset.

Decomposition:
- Package run_dump_pkg: state enum; default parameter constants; helper function for line-end detection.
- One sub-module, dump_engine: owns the RD_REQ/RD_CAP/OUT sub-FSM, index counter, address adder and handshake. Top level keeps reset hold, RUN, PC compare and timeout.

Test Plan:
- Reset=0 during Clk activity -> Core_Reset=1, Busy=0, Done=0, Out_Valid=0, Cycle_Count=0; Start pulsed while Reset=0 has no effect.
- Start with RESET_CYCLES=3 -> Core_Reset high exactly 3 cycles, then 0; Busy=1 from the cycle after Start.
- PC model reaches End_PC=0x8c on the 50th RUN cycle; Dump_Base=32, Dump_Len=96, WORDS_PER_LINE=16, Out_Ready=1 -> Cycle_Count=50, Timeout=0; 96 beats with data = mem[32..127]; Out_Eol on beats 16,32,...,96; Out_Last only on beat 96; Done=1.
- Same run with Out_Ready random at 30% -> identical beat sequence; Out_Data/Eol/Last stable during every stall; no beat lost or duplicated.
- MAX_CYCLES=100, PC never matches -> exit after 100 RUN cycles with Timeout=1, Cycle_Count=100; dump still completes, Done=1.
- Dump_Base=2^ADDR_W-2, Dump_Len=4 -> Mem_Addr sequence all-ones-minus-1, all-ones, 0, 1. Dump_Len=0 -> Done with zero beats. Reset=0 asserted during beat 2 -> all outputs to reset values the same cycle.
